// File: rtl/overlap_add_packer_if.sv
// AXI-Stream style bus used on both sides of the overlap-add packer.
//   tdata  : sample (WIDTH bits)
//   tvalid : source has a beat
//   tready : sink accepts the beat
//   tlast  : final beat of a packet
interface overlap_add_packer_if #(
   parameter int WIDTH = 8
) ();
   logic [WIDTH-1:0] tdata;
   logic             tvalid;
   logic             tready;
   logic             tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/overlap_add_packer.sv
// Overlap-add packer for fixed-length packets of N samples.
// The last K samples of every packet are kept in a tail buffer and added to
// the first K samples of the following packet; the first N-K samples of each
// packet are emitted through a single output register stage.
//
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   cfg_len, cfg_overlap  : N and K, sampled on the first beat of a packet
//   flush                 : emit the stored tail as its own packet
//   s_axis (slave)        : input samples, DATA_WIDTH bits
//   m_axis (master)       : output samples, DATA_WIDTH+1 bits
//   cfg_err               : latched, packet started with an invalid N/K
//   pkt_err               : one-cycle pulse on a framing error
//
// state | meaning
// IDLE  | no packet in progress
// RUN   | packet in progress
// FLUSH | emitting the stored tail
module overlap_add_packer #(
   parameter int DATA_WIDTH  = 8,
   parameter int LEN_WIDTH   = 8,
   parameter int MAX_OVERLAP = 128,
   parameter int SIGNED      = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [LEN_WIDTH-1:0] cfg_len,
   input  logic [LEN_WIDTH-1:0] cfg_overlap,
   input  logic                 flush,
   overlap_add_packer_if.slave  s_axis,
   overlap_add_packer_if.master m_axis,
   output logic                 cfg_err,
   output logic                 pkt_err
);
   localparam int IDX_W = (MAX_OVERLAP > 1) ? $clog2(MAX_OVERLAP) : 1;
   localparam logic [LEN_WIDTH:0] MAX_K = (LEN_WIDTH+1)'(MAX_OVERLAP);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t                 state, state_nxt;
   logic [LEN_WIDTH-1:0]   cnt, n_q, k_q, tail_len;
   logic                   flush_pend;
   logic [DATA_WIDTH-1:0]  tail_mem [MAX_OVERLAP];
   logic [DATA_WIDTH:0]    out_data;
   logic                   out_valid, out_last;

   logic                   cfg_ok, out_free, flush_go;
   logic [LEN_WIDTH-1:0]   cur_n, cur_k, cur_c, head_len;
   logic                   in_tail, last_idx;
   logic [DATA_WIDTH-1:0]  tail_rd;
   logic                   s_ready, accept, head_load, flush_load, pkt_done, flush_done;

   function automatic logic [DATA_WIDTH:0] ext(input logic [DATA_WIDTH-1:0] v);
      return {(SIGNED != 0) & v[DATA_WIDTH-1], v};
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (flush_go) state_nxt = FLUSH;
                  else if (accept && !pkt_done) state_nxt = RUN;
         RUN:     if (pkt_done) state_nxt = IDLE;
         FLUSH:   if (flush_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // In IDLE the beat being offered is beat 0 of a new packet, so its
   // geometry comes straight from the config inputs rather than the latches.
   always_comb begin
      cfg_ok     = (cfg_overlap == '0) ||
                   ((({1'b0, cfg_overlap} << 1) <= {1'b0, cfg_len}) && ({1'b0, cfg_overlap} <= MAX_K));
      cur_n      = (state == IDLE) ? cfg_len : n_q;
      cur_k      = (state == IDLE) ? (cfg_ok ? cfg_overlap : '0) : k_q;
      cur_c      = (state == IDLE) ? '0 : cnt;
      head_len   = cur_n - cur_k;
      in_tail    = (state != FLUSH) && (cur_c >= head_len);
      last_idx   = cur_c == cur_n - LEN_WIDTH'(1);
      tail_rd    = (cur_c < tail_len) ? tail_mem[cur_c[IDX_W-1:0]] : '0;
      out_free   = !out_valid || m_axis.tready;
      flush_go   = (state == IDLE) && (flush || flush_pend) && (tail_len != '0);
      s_ready    = reset_n && (state != FLUSH) && !flush_go && (in_tail || out_free);
      accept     = s_axis.tvalid && s_ready;
      head_load  = accept && !in_tail;
      pkt_done   = accept && (last_idx || s_axis.tlast);
      flush_load = (state == FLUSH) && out_free;
      flush_done = flush_load && (cnt == tail_len - LEN_WIDTH'(1));
   end

   assign s_axis.tready = s_ready;
   assign m_axis.tdata  = out_data;
   assign m_axis.tvalid = out_valid;
   assign m_axis.tlast  = out_last;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt        <= '0;
         n_q        <= '0;
         k_q        <= '0;
         tail_len   <= '0;
         flush_pend <= 1'b0;
         cfg_err    <= 1'b0;
         pkt_err    <= 1'b0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
      end else begin
         pkt_err <= 1'b0;
         // A flush seen outside IDLE waits; in IDLE it is either taken or dropped.
         flush_pend <= (state != IDLE) ? (flush || flush_pend) : 1'b0;

         if (accept && state == IDLE) begin
            n_q     <= cfg_len;
            k_q     <= cur_k;
            cfg_err <= !cfg_ok;
         end

         if (flush_go)        cnt <= '0;
         else if (flush_load) cnt <= cnt + LEN_WIDTH'(1);
         else if (accept)     cnt <= pkt_done ? '0 : cur_c + LEN_WIDTH'(1);

         // Early tlast discards the tail; a full-length packet keeps it even
         // when tlast is missing.
         if (pkt_done) begin
            tail_len <= last_idx ? cur_k : '0;
            pkt_err  <= last_idx ^ s_axis.tlast;
         end else if (flush_done) begin
            tail_len <= '0;
         end

         if (head_load) begin
            out_data  <= ext(s_axis.tdata) + ((cur_c < cur_k) ? ext(tail_rd) : '0);
            out_last  <= (cur_c == head_len - LEN_WIDTH'(1)) || s_axis.tlast;
            out_valid <= 1'b1;
         end else if (flush_load) begin
            out_data  <= ext(tail_rd);
            out_last  <= flush_done;
            out_valid <= 1'b1;
         end else if (m_axis.tready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Tail reads of a packet finish before its tail writes start, so the
   // buffer is overwritten in place.
   always_ff @(posedge clk) begin
      if (accept && in_tail)
         tail_mem[IDX_W'(cur_c - head_len)] <= s_axis.tdata;
   end
endmodule

// File: doc/overlap_add_packer.md
Name: overlap_add_packer

Overview:
- Parametrised AXI-Stream overlap-add packer for fixed-length packets of N samples.
- The last K samples of each input packet are held in an internal tail buffer.
- The tail is added sample-wise to the first K samples of the next packet; the first N-K samples of each packet are emitted.
- Supports runtime N/K, signed or unsigned arithmetic, an explicit tail flush, and error reporting for bad configuration or framing.

Parameters:
- DATA_WIDTH, 8, input sample width; output is DATA_WIDTH+1.
- LEN_WIDTH, 8, width of cfg_len/cfg_overlap; maximum N = 2^LEN_WIDTH-1.
- MAX_OVERLAP, 128, tail buffer depth; K above this is a config error.
- SIGNED, 0, 1 = sign-extend operands before the add; 0 = zero-extend.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cfg_len  in  LEN_WIDTH  packet length N
- cfg_overlap  in  LEN_WIDTH  overlap K
- flush  in  1  request emission of the stored tail as its own packet
- s_axis_tdata  in  DATA_WIDTH  input sample
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tlast  in  1
- m_axis_tdata  out  DATA_WIDTH+1  output sample
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- cfg_err  out  1  latched configuration invalid
- pkt_err  out  1  one-cycle pulse on framing error

Behaviour:
- Interface: one clock domain (clk). reset_n is asynchronous, active-low.
- Reset values:
  - All outputs 0; s_axis_tready=0 while reset_n=0.
  - Tail marked empty (reads as zeros); counters 0; state IDLE.
  - Reset mid-packet discards the packet and the tail.
- States:
  - IDLE: no packet in progress.
  - RUN: packet in progress.
  - FLUSH: emitting the stored tail.
  - IDLE->RUN on the first accepted beat.
  - RUN->IDLE after beat N-1 or on early tlast.
  - IDLE->FLUSH when flush=1 and the tail is non-empty; flush in RUN is held pending until IDLE.
  - FLUSH->IDLE after tail beat K-1 is accepted downstream.
  - flush with an empty tail is ignored.
- Config latch: N and K are sampled on the first beat of each packet and held for the whole packet.
  - If K=0 or 2K<=N and K<=MAX_OVERLAP: valid config.
  - Otherwise: cfg_err=1 and the packet runs with K=0 (passthrough); cfg_err clears at the next packet start with a valid config.
- Beat index c (0..N-1), handled by region:
  - c<K: output sext/zext(din)+sext/zext(tail[c]), computed at DATA_WIDTH+1 with no overflow possible.
  - K<=c<N-K: output din extended to DATA_WIDTH+1.
  - c>=N-K: tail[c-(N-K)] <= din; no output beat.
  - m_axis_tlast=1 on index N-K-1.
  - Because 2K<=N, all tail reads of a packet complete before its tail writes begin, so a single buffer suffices.
- Handshake:
  - Output is a single register stage; latency is 1 cycle from input acceptance to m_axis_tvalid.
  - out_free = !m_axis_tvalid | m_axis_tready.
  - s_axis_tready = out_free for output-region beats; 1 for tail-region beats; 0 in FLUSH.
  - m_axis_tdata/tlast are held stable while tvalid=1 and tready=0.
- FLUSH: emits tail[0..K-1] extended to DATA_WIDTH+1, tlast on K-1; the tail is then empty.
- Framing errors:
  - tlast at c<N-K: beat emitted with m_axis_tlast=1, tail cleared, pkt_err pulses.
  - tlast at c>=N-K, c<N-1: beat dropped, tail cleared, pkt_err pulses.
  - No tlast at c=N-1: packet closed normally (tail kept), pkt_err pulses; the next beat starts a new packet.
- First packet after reset or flush sums with a zero tail.

Test Plan:
1. N=8,K=2, packets 1..8 then 11..18 -> outputs 1,2,3,4,5,6 (tlast on 6), then 18,20,13,14,15,16 (tlast on 16); tail holds 17,18.
2. Case 1 followed by flush -> packet 17,18 with tlast on 18; a second flush produces no output.
3. N=8,K=5 -> cfg_err=1, 8 beats passed through unchanged with tlast on beat 8; next packet with K=2 clears cfg_err.
4. DATA_WIDTH=8, tail byte 0xFF, next-packet first byte 0x01 -> SIGNED=0 gives 9'h100; SIGNED=1 gives 9'h000.
5. Case 1 with m_axis_tready toggled 1-0-0-1 and random s_axis_tvalid gaps -> identical output sequence; no drops or duplicates; data held stable while stalled.
6. N=8,K=2, tlast on c=3 -> 4 beats out (last with tlast), pkt_err pulse; next packet sums with zero tail. Repeat with reset_n low at c=5 -> outputs 0, tail empty.
